pc_unit: RTL and testbench

- Parametrised fetch-stage program counter; successor to the basic 32-bit PC register.
- Adds reset vector, sequential increment, stall hold, execute-stage redirect and a circular return-address stack (RAS) for call/return prediction.
- Sits between branch/jump resolution logic and instruction memory; current_pc drives the IMEM address.

---
 rtl/pc_pkg.sv | 21 ++
 rtl/pc_ras.sv | 67 ++++++
 rtl/pc_unit.sv | 111 +++++++++++
 tb/tb_pc_unit.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared constants, next-PC source encoding and sizing helper for the fetch PC unit.
package pc_pkg;

  localparam int XLEN_DEF         = 32;
  localparam int RESET_VECTOR_DEF = 0;
  localparam int INC_BYTES_DEF    = 4;
  localparam int RAS_DEPTH_DEF    = 4;

  typedef enum logic [1:0] {
    SRC_SEQ,
    SRC_REDIRECT,
    SRC_RAS,
    SRC_HOLD
  } pc_src_e;

  // Pointer width for a circular buffer; never narrower than one bit.
  function automatic int ptr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: push, pop, push+pop replace, saturating count.
// Entry storage is intentionally not reset; only pointer and count are.
module pc_ras
  import pc_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int DEPTH = RAS_DEPTH_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top_data,
  output logic            empty,
  output logic            full
);

  localparam int            PW        = ptr_width(DEPTH);
  localparam logic [PW:0]   DEPTH_CNT = (PW+1)'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [PW:0]   CNT_ONE   = (PW+1)'(1);

  logic [XLEN-1:0] entries [DEPTH];
  logic [PW-1:0]   top_ptr;
  logic [PW-1:0]   ptr_inc;
  logic [PW-1:0]   ptr_dec;
  logic [PW:0]     count;
  logic            do_push;
  logic            do_pop;
  logic            do_replace;

  assign ptr_inc  = top_ptr + PTR_ONE;
  assign ptr_dec  = top_ptr - PTR_ONE;
  assign empty    = (count == '0);
  assign full     = (count == DEPTH_CNT);
  assign top_data = entries[top_ptr];

  // A pop from an empty stack is dropped, so a simultaneous push then acts alone.
  assign do_replace = push & pop & ~empty;
  assign do_pop     = pop & ~push & ~empty;
  assign do_push    = push & ~(pop & ~empty);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      top_ptr <= '0;
      count   <= '0;
    end else if (do_push) begin
      top_ptr <= ptr_inc;
      if (!full) begin
        count <= count + CNT_ONE;
      end
    end else if (do_pop) begin
      top_ptr <= ptr_dec;
      count   <= count - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      entries[ptr_inc] <= push_data;
    end else if (do_replace) begin
      entries[top_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter with redirect, stall, and RAS-based return prediction.
// Optional redirect alignment check enabled by defining PC_MISALIGN_CHK_EN.
module pc_unit
  import pc_pkg::*;
#(
  parameter int               XLEN         = XLEN_DEF,
  parameter logic [XLEN-1:0]  RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
  parameter int               INC_BYTES    = INC_BYTES_DEF,
  parameter int               RAS_DEPTH    = RAS_DEPTH_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            call_push,
  input  logic            ret_pop,
  output logic [XLEN-1:0] current_pc,
  output logic [XLEN-1:0] pc_plus_inc,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_miss,
  output logic            misalign_err
);

  localparam logic [XLEN-1:0] INC_VAL = XLEN'(INC_BYTES);

  pc_src_e         next_src;
  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] ras_top;
  logic            advance;
  logic            ras_push;
  logic            ras_pop;
  logic            miss_next;
  logic            redirect_bad;

  assign pc_plus_inc = current_pc + INC_VAL;

`ifdef PC_MISALIGN_CHK_EN
  // With INC_BYTES=1 the mask is zero, so every target counts as aligned.
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INC_BYTES - 1);

  logic misalign_q;

  assign redirect_bad = redirect_valid && ((redirect_target & ALIGN_MASK) != '0);
  assign misalign_err = misalign_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= redirect_bad;
    end
  end
`else
  assign redirect_bad = 1'b0;
  assign misalign_err = 1'b0;
`endif

  // RAS activity only happens on a normal advancing cycle.
  assign advance   = !redirect_valid && !stall;
  assign ras_push  = advance && call_push;
  assign ras_pop   = advance && ret_pop && !ras_empty;
  assign miss_next = advance && ret_pop && ras_empty;

  always_comb begin
    next_src = SRC_SEQ;
    if (redirect_valid) begin
      next_src = redirect_bad ? SRC_HOLD : SRC_REDIRECT;
    end else if (stall) begin
      next_src = SRC_HOLD;
    end else if (ret_pop && !ras_empty) begin
      next_src = SRC_RAS;
    end
  end

  always_comb begin
    next_pc = pc_plus_inc;
    case (next_src)
      SRC_REDIRECT: next_pc = redirect_target;
      SRC_RAS:      next_pc = ras_top;
      SRC_HOLD:     next_pc = current_pc;
      default:      next_pc = pc_plus_inc;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      current_pc <= RESET_VECTOR;
      ras_miss   <= 1'b0;
    end else begin
      current_pc <= next_pc;
      ras_miss   <= miss_next;
    end
  end

  pc_ras #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_plus_inc),
    .top_data  (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed vector table, corner sequences, and
// randomized traffic against a queue-based return-stack model.
module tb_pc_unit;

  localparam int DEPTH = 4;
  localparam int INC   = 4;

`ifdef PC_MISALIGN_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        call_push = 1'b0;
  logic        ret_pop = 1'b0;

  logic [31:0] current_pc, pc_plus_inc;
  logic        ras_empty, ras_full, ras_miss, misalign_err;
  logic [31:0] w_pc, w_plus;
  logic        w_empty, w_full, w_miss, w_mis;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference state: the stack is a bounded queue, newest entry at the back.
  logic [31:0] m_pc;
  logic [31:0] m_q[$];
  logic        m_miss;
  logic        m_mis;

  typedef struct {
    string       name;
    logic        st;
    logic        rv;
    logic [31:0] rt;
    logic        cp;
    logic        rp;
    logic [31:0] exp_pc;
    logic        exp_empty;
    logic        exp_miss;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[$];

  pc_unit dut (
    .clk (clk), .reset (reset), .stall (stall),
    .redirect_valid (redirect_valid), .redirect_target (redirect_target),
    .call_push (call_push), .ret_pop (ret_pop),
    .current_pc (current_pc), .pc_plus_inc (pc_plus_inc),
    .ras_empty (ras_empty), .ras_full (ras_full),
    .ras_miss (ras_miss), .misalign_err (misalign_err)
  );

  pc_unit #(.RESET_VECTOR (32'hFFFF_FFF8)) dut_wrap (
    .clk (clk), .reset (reset), .stall (stall),
    .redirect_valid (redirect_valid), .redirect_target (redirect_target),
    .call_push (call_push), .ret_pop (ret_pop),
    .current_pc (w_pc), .pc_plus_inc (w_plus),
    .ras_empty (w_empty), .ras_full (w_full),
    .ras_miss (w_miss), .misalign_err (w_mis)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  function automatic bit is_misaligned(input logic [31:0] t);
    return CHK_EN && ((t % INC) != 0);
  endfunction

  task automatic model_reset();
    m_pc   = 32'h0;
    m_q.delete();
    m_miss = 1'b0;
    m_mis  = 1'b0;
  endtask

  task automatic model_step(input logic st, input logic rv, input logic [31:0] rt,
                            input logic cp, input logic rp);
    logic [31:0] seq;
    logic [31:0] npc;
    seq    = m_pc + INC;
    npc    = seq;
    m_miss = 1'b0;
    m_mis  = 1'b0;
    if (rv) begin
      if (is_misaligned(rt)) m_mis = 1'b1;
      else m_pc = rt;
    end else if (!st) begin
      if (rp) begin
        if (m_q.size() > 0) npc = m_q.pop_back();
        else m_miss = 1'b1;
      end
      if (cp) begin
        m_q.push_back(seq);
        if (m_q.size() > DEPTH) void'(m_q.pop_front());
      end
      m_pc = npc;
    end
  endtask

  task automatic applyStimulus(input logic st, input logic rv, input logic [31:0] rt,
                               input logic cp, input logic rp);
    stall           = st;
    redirect_valid  = rv;
    redirect_target = rt;
    call_push       = cp;
    ret_pop         = rp;
    model_step(st, rv, rt, cp, rp);
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    checkOutput({tag, " pc"},   current_pc,   m_pc);
    checkOutput({tag, " plus"}, pc_plus_inc,  m_pc + INC);
    checkOutput({tag, " empty"}, 32'(ras_empty), 32'(m_q.size() == 0));
    checkOutput({tag, " full"},  32'(ras_full),  32'(m_q.size() == DEPTH));
    checkOutput({tag, " miss"},  32'(ras_miss),  32'(m_miss));
    checkOutput({tag, " misalign"}, 32'(misalign_err), 32'(m_mis));
  endtask

  task automatic checked_cycle(input string name, input logic st, input logic rv,
                               input logic [31:0] rt, input logic cp, input logic rp,
                               input logic [31:0] exp_pc, input logic exp_empty,
                               input logic exp_full, input logic exp_miss);
    applyStimulus(st, rv, rt, cp, rp);
    checkOutput({name, " pc"},    current_pc, exp_pc);
    checkOutput({name, " empty"}, 32'(ras_empty), 32'(exp_empty));
    checkOutput({name, " full"},  32'(ras_full),  32'(exp_full));
    checkOutput({name, " miss"},  32'(ras_miss),  32'(exp_miss));
  endtask

  task automatic do_reset();
    stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    call_push = 1'b0; ret_pop = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset pc",       current_pc, 32'h0);
    checkOutput("reset empty",    32'(ras_empty), 32'd1);
    checkOutput("reset full",     32'(ras_full), 32'd0);
    checkOutput("reset miss",     32'(ras_miss), 32'd0);
    checkOutput("reset misalign", 32'(misalign_err), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [31:0] pop_exp [4];
    logic        rv, st, cp, rp;
    logic [31:0] rt;

    // Reset vector, sequential increment and 32-bit wrap on the second instance.
    do_reset();
    checkOutput("wrap reset pc", w_pc, 32'hFFFF_FFF8);
    checkOutput("wrap reset plus", w_plus, 32'hFFFF_FFFC);
    checkOutput("wrap reset flags", {28'd0, w_empty, w_full, w_miss, w_mis}, 32'h8);
    checked_cycle("seq1", 0, 0, 0, 0, 0, 32'h4, 1, 0, 0);
    checkOutput("wrap seq1 pc", w_pc, 32'hFFFF_FFFC);
    checked_cycle("seq2", 0, 0, 0, 0, 0, 32'h8, 1, 0, 0);
    checkOutput("wrap seq2 pc", w_pc, 32'h0000_0000);

    vecs.push_back('{"stall a",       1, 0, 32'h0,   0, 0, 32'h8,   1, 0, 0});
    vecs.push_back('{"stall b",       1, 0, 32'h0,   0, 0, 32'h8,   1, 0, 0});
    vecs.push_back('{"stall+redir",   1, 1, 32'h100, 0, 0, 32'h100, 1, 0, 0});
    vecs.push_back('{"redir 10",      0, 1, 32'h10,  0, 0, 32'h10,  1, 0, 0});
    vecs.push_back('{"call at 10",    0, 0, 32'h0,   1, 0, 32'h14,  0, 0, 0});
    vecs.push_back('{"redir 200",     0, 1, 32'h200, 0, 0, 32'h200, 0, 0, 0});
    vecs.push_back('{"ret at 200",    0, 0, 32'h0,   0, 1, 32'h14,  1, 0, 0});
    vecs.push_back('{"redir 20",      0, 1, 32'h20,  0, 0, 32'h20,  1, 0, 0});
    vecs.push_back('{"redir 102",     0, 1, 32'h102, 0, 0, CHK_EN ? 32'h20 : 32'h102, 1, 0, CHK_EN});
    vecs.push_back('{"after misalign", 0, 0, 32'h0,  0, 0, CHK_EN ? 32'h24 : 32'h106, 1, 0, 0});
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].st, vecs[i].rv, vecs[i].rt, vecs[i].cp, vecs[i].rp);
      checkOutput({vecs[i].name, " pc"},       current_pc, vecs[i].exp_pc);
      checkOutput({vecs[i].name, " empty"},    32'(ras_empty), 32'(vecs[i].exp_empty));
      checkOutput({vecs[i].name, " miss"},     32'(ras_miss), 32'(vecs[i].exp_miss));
      checkOutput({vecs[i].name, " misalign"}, 32'(misalign_err), 32'(vecs[i].exp_mis));
    end

    // Six pushes into a four-deep stack keep only the newest four returns.
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      checked_cycle($sformatf("push%0d", i), 0, 0, 0, 1, 0, 32'(4 * i), 0, i >= 4, 0);
    end
    pop_exp = '{32'h18, 32'h14, 32'h10, 32'hC};
    for (int i = 0; i < 4; i++) begin
      checked_cycle($sformatf("pop%0d", i + 1), 0, 0, 0, 0, 1, pop_exp[i], i == 3, 0, 0);
    end
    checked_cycle("pop empty", 0, 0, 0, 0, 1, 32'h10, 1, 0, 1);
    checked_cycle("miss clears", 0, 0, 0, 0, 0, 32'h14, 1, 0, 0);

    // Simultaneous push and pop replaces the top entry.
    do_reset();
    checked_cycle("redir 3c",  0, 1, 32'h3C, 0, 0, 32'h3C, 1, 0, 0);
    checked_cycle("call 3c",   0, 0, 0, 1, 0, 32'h40, 0, 0, 0);
    checked_cycle("redir 80",  0, 1, 32'h80, 0, 0, 32'h80, 0, 0, 0);
    checked_cycle("push+pop",  0, 0, 0, 1, 1, 32'h40, 0, 0, 0);
    checked_cycle("pop new top", 0, 0, 0, 0, 1, 32'h84, 1, 0, 0);

    // Reset asserted between edges takes effect without waiting for a clock.
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      checked_cycle($sformatf("fill%0d", i), 0, 0, 0, 1, 0, 32'(4 * i), 0, 0, 0);
    end
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async reset pc", current_pc, 32'h0);
    checkOutput("async reset empty", 32'(ras_empty), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    checked_cycle("post async", 0, 0, 0, 0, 0, 32'h4, 1, 0, 0);

    // Randomized traffic against the reference model.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      st = ($urandom_range(0, 9) < 2);
      rv = ($urandom_range(0, 9) == 0);
      rt = $urandom() & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) rt = rt | 32'($urandom_range(1, 3));
      cp = ($urandom_range(0, 9) < 3);
      rp = ($urandom_range(0, 9) < 3);
      applyStimulus(st, rv, rt, cp, rp);
      check_model($sformatf("rand%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
